// File: rtl/word_byte_serializer_if.sv
// Word-in / byte-out handshake bundle for word_byte_serializer.
// master: upstream word source plus downstream byte sink (drives in_data,
//         in_valid, out_ready).
// slave : the serializer itself.
interface word_byte_serializer_if;

    // Upstream word channel
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;

    // Downstream byte channel
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_idx;
    logic        out_last;

    // Status
    logic        busy;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_byte,
        input  out_valid,
        input  out_idx,
        input  out_last,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_byte,
        output out_valid,
        output out_idx,
        output out_last,
        output busy
    );

endinterface

// File: rtl/word_byte_serializer.sv
// word_byte_serializer: holds one 32-bit word and emits it as four bytes,
// one per out_valid/out_ready handshake. A new word is accepted in the same
// cycle the last byte leaves, so back-to-back words stream without bubbles.
//
// Build option:
//   WORD_SER_LSB_FIRST_EN undefined -> byte 0 = word[31:24] (MSB first)
//   WORD_SER_LSB_FIRST_EN defined   -> byte 0 = word[7:0]   (LSB first)
// out_idx / out_last behave identically in both builds.
module word_byte_serializer #(
    parameter int NBYTES = 4,   // only 4 is supported
    parameter int BYTE_W = 8    // only 8 is supported
) (
    input  logic                  clk,
    input  logic                  rst_n,
    word_byte_serializer_if.slave bus
);

    localparam int         WORD_W   = NBYTES * BYTE_W;
    localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          idx_q,   idx_d;
    logic [WORD_W-1:0]   word_q,  word_d;

    logic                at_last;
    logic                in_ready_c;
    logic                in_hs;
    logic                out_hs;
    logic [1:0]          lane;
    logic [BYTE_W-1:0]   byte_sel;

    // Handshake qualification; in_ready depends only on state and out_ready.
    always_comb begin
        at_last    = (state_q == SEND) && (idx_q == LAST_IDX);
        in_ready_c = rst_n && ((state_q == IDLE) || (at_last && bus.out_ready));
        in_hs      = bus.in_valid && in_ready_c;
        out_hs     = (state_q == SEND) && bus.out_ready;
    end

    // Next-state logic: load, walk the byte counter, reload or drain.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;

        case (state_q)
            IDLE: begin
                if (in_hs) begin
                    state_d = SEND;
                    idx_d   = 2'd0;
                    word_d  = bus.in_data;
                end
            end

            SEND: begin
                if (out_hs) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + 2'd1;
                    end else if (in_hs) begin
                        // Last byte leaves and the next word arrives together.
                        idx_d  = 2'd0;
                        word_d = bus.in_data;
                    end else begin
                        state_d = IDLE;
                        idx_d   = 2'd0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    // Byte lane select: map the walk index onto a byte lane of the word.
    always_comb begin
`ifdef WORD_SER_LSB_FIRST_EN
        lane = idx_q;
`else
        lane = LAST_IDX - idx_q;
`endif
        case (lane)
            2'd0:    byte_sel = word_q[7:0];
            2'd1:    byte_sel = word_q[15:8];
            2'd2:    byte_sel = word_q[23:16];
            default: byte_sel = word_q[31:24];
        endcase
    end

    // State, counter and word register; reset aborts any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the word register is cleared too, so out_byte reads 0x00 in reset.
            state_q <= IDLE;
            idx_q   <= 2'd0;
            word_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == SEND);
    assign bus.busy      = (state_q == SEND);
    assign bus.out_last  = at_last;
    assign bus.out_idx   = idx_q;
    assign bus.out_byte  = byte_sel;

endmodule

// File: doc/word_byte_serializer.md
# word_byte_serializer

Converts a 32-bit word into a stream of four bytes, one per handshake, in the same byte order the word splitter produces (byte 0 = bits [31:24], byte 3 = bits [7:0]). It sits directly downstream of the splitter stage and feeds byte-wide consumers such as a UART transmitter or a display scanner. The block holds one word, walks it with a 2-bit byte counter, and accepts the next word on the same cycle the last byte leaves, so back-to-back words produce no bubbles.

## Interface
- NBYTES, 4, bytes per word; fixed at 4, and other values are unsupported.
- BYTE_W, 8, bits per byte; the word width is NBYTES*BYTE_W = 32.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  32  word to serialize; sampled only on an input handshake
- in_valid  input  1  upstream word is valid
- in_ready  output  1  block can accept a word this cycle
- out_byte  output  8  current byte
- out_valid  output  1  out_byte is valid
- out_ready  input  1  downstream accepts the byte
- out_idx  output  2  index of the current byte within its word (0..3)
- out_last  output  1  current byte is byte 3 of its word
- busy  output  1  a word is held (state SEND)

## Operation
- Input handshake: in_valid && in_ready at a rising edge. Output handshake: out_valid && out_ready at a rising edge.
- States:
  - IDLE: no word held.
  - SEND: word register holds a word; idx counter selects the byte.
- IDLE -> SEND on an input handshake: load the word register from in_data; idx = 0.
- SEND, output handshake with idx < 3: idx increments.
- SEND, output handshake with idx = 3:
  - If an input handshake occurs in the same cycle: load the new word, idx = 0, stay in SEND.
  - Otherwise: go to IDLE.
- in_ready = rst_n && (IDLE || (SEND && idx==3 && out_ready)). This is combinational from state and out_ready. There is no path from in_valid to in_ready.
- out_valid = SEND. busy = SEND. out_last = SEND && idx==3. out_idx = idx.
- out_byte = word[31-8*idx -: 8] (MSB-first order), or LSB-first when the configuration macro is defined.
- While out_valid && !out_ready:
  - out_byte, out_idx and out_last stay stable.
  - The word register ignores in_data.
- in_valid while in SEND with idx < 3: no effect. Upstream must hold the word until in_ready is asserted.
- out_ready while in IDLE: ignored.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, idx = 0, word register = 0.
  - Outputs: out_valid 0, out_byte 0x00, out_idx 0, out_last 0, busy 0, in_ready 0.
- A reset asserted mid-word aborts that word immediately. The remaining bytes are discarded and no partial word is resumed after reset.
- First rising edge after rst_n goes high: in_ready = 1 (IDLE).
- Latency: a word accepted at edge N presents byte 0 with out_valid = 1 after edge N.
- Throughput: with out_ready held at 1, the four bytes occupy cycles N+1..N+4. The next word is accepted at edge N+4, and its byte 0 appears in cycle N+5 (one byte per cycle sustained).
- Each byte stays on out_byte for at least one cycle and until its handshake.

## Configuration
- WORD_SER_LSB_FIRST_EN:
  - Undefined (default): byte order is MSB first, matching the splitter outputs O1..O4, i.e. out_byte = word[31:24], [23:16], [15:8], [7:0] for idx 0..3.
  - Defined: byte order is reversed to word[7:0], [15:8], [23:16], [31:24].
- All other behaviour, including out_idx and out_last, is identical in both builds.

## Test plan
- Reset check: hold rst_n low with in_valid = 1 and in_data = 0xFFFFFFFF.
  - During reset: all outputs are 0, including in_ready.
  - After release: in_ready = 1 and out_valid = 0.
- Single word: in_data = 0x01020304, out_ready = 1.
  - Output is bytes 01, 02, 03, 04 with out_idx 0..3.
  - out_last is high only on 04; the block then returns to IDLE with busy = 0.
- Back-to-back words: 0x11111111 then 0x00002222, in_valid held, out_ready = 1.
  - Output is eight consecutive cycles of 11, 11, 11, 11, 00, 00, 22, 22 with no gap.
  - in_ready pulses for exactly one cycle, together with the first word's last byte.
- Backpressure: word 0x00003333 with out_ready low for 3 cycles at idx = 1.
  - out_byte stays 0x00 and out_idx stays 1 for those cycles.
  - Changing in_data during the stall has no effect; the sequence resumes 00, 33, 33.
- Abort: word 0xAABBCCDD, assert rst_n low after byte BB has been transferred.
  - The block is in IDLE immediately, and CC/DD are never output.
  - A new word 0x01020304 then serializes from byte 0.
- LSB-first build (WORD_SER_LSB_FIRST_EN defined): in_data = 0x01020304.
  - Output is 04, 03, 02, 01, with out_last on 01.
